// File: rtl/memaccess_hs.sv
// Memory access stage driving data memory over a req/gnt/rvalid handshake.
// Steers store lanes, extends load data, flags misaligned/timeout, and feeds the MA->WB register.
module memaccess_hs #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MAREGclear,
  input  logic               MAREGstall,
  input  logic               in_valid,
  input  logic [4:0]         in_rd,
  input  logic [WIDTH-1:0]   in_aluresult,
  input  logic [WIDTH-1:0]   in_reg2data,
  input  logic [WIDTH-1:0]   in_pc,
  input  logic               in_regwrite,
  input  logic [1:0]         in_mem2reg,
  input  logic               in_memread,
  input  logic               in_memwrite,
  input  logic [2:0]         in_funct3,
  output logic               ma_busy,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [WIDTH-1:0]   dmem_addr,
  output logic [WIDTH/8-1:0] dmem_be,
  output logic [WIDTH-1:0]   dmem_wdata,
  input  logic               dmem_gnt,
  input  logic               dmem_rvalid,
  input  logic [WIDTH-1:0]   dmem_rdata,
  output logic               out_valid,
  output logic [4:0]         out_rd,
  output logic [WIDTH-1:0]   out_result,
  output logic [WIDTH-1:0]   out_dmemdata,
  output logic [WIDTH-1:0]   out_pc,
  output logic               out_regwrite,
  output logic [1:0]         out_mem2reg,
  output logic [1:0]         out_exc
);

  localparam int unsigned BEW  = WIDTH / 8;
  localparam int unsigned OFFW = $clog2(BEW);
  localparam int unsigned CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic             kill_q, kill_d;
  logic [CW-1:0]    cnt_q;
  logic [4:0]       hold_rd_q;
  logic [WIDTH-1:0] hold_addr_q;
  logic [WIDTH-1:0] hold_wdata_q;
  logic [BEW-1:0]   hold_be_q;
  logic [WIDTH-1:0] hold_pc_q;
  logic             hold_regwrite_q;
  logic [1:0]       hold_mem2reg_q;
  logic             hold_we_q;
  logic [2:0]       hold_funct3_q;
  logic [WIDTH-1:0] hold_data_q;
  logic [1:0]       hold_exc_q;

  logic [OFFW-1:0]  in_off;
  logic [1:0]       in_size;
  logic             in_mem, in_legal, in_misal, in_bad;
  logic [BEW-1:0]   in_be;
  logic [WIDTH-1:0] in_wdata;
  logic             accept, go_bus, timeout_hit, to_fire;
  logic [WIDTH-1:0] lane, ld_data;

  // Incoming op decode: legality, alignment, lane enables and replicated store data
  always_comb begin
    in_off  = in_aluresult[OFFW-1:0];
    in_size = in_funct3[1:0];
    in_mem  = in_memread | in_memwrite;
    in_legal = 1'b1;
    if (in_funct3 == 3'b111) in_legal = 1'b0;
    if (in_memwrite && in_funct3[2]) in_legal = 1'b0;
    if ((WIDTH == 32) && ((in_size == 2'd3) || (in_funct3 == 3'b110))) in_legal = 1'b0;
    case (in_size)
      2'd0:    in_misal = 1'b0;
      2'd1:    in_misal = in_off[0];
      2'd2:    in_misal = |in_off[1:0];
      default: in_misal = |in_off;
    endcase
    in_bad = in_mem && (!in_legal || in_misal);
    case (in_size)
      2'd0:    in_be = BEW'(1) << in_off;
      2'd1:    in_be = BEW'(3) << in_off;
      2'd2:    in_be = BEW'(15) << in_off;
      default: in_be = '1;
    endcase
    case (in_size)
      2'd0:    in_wdata = {BEW{in_reg2data[7:0]}};
      2'd1:    in_wdata = {(WIDTH/16){in_reg2data[15:0]}};
      2'd2:    in_wdata = {(WIDTH/32){in_reg2data[31:0]}};
      default: in_wdata = in_reg2data;
    endcase
  end

  always_comb begin
    lane = dmem_rdata >> {hold_addr_q[OFFW-1:0], 3'b000};
    case (hold_funct3_q)
      3'b000:  ld_data = WIDTH'($signed(lane[7:0]));
      3'b001:  ld_data = WIDTH'($signed(lane[15:0]));
      3'b010:  ld_data = WIDTH'($signed(lane[31:0]));
      3'b100:  ld_data = WIDTH'(lane[7:0]);
      3'b101:  ld_data = WIDTH'(lane[15:0]);
      3'b110:  ld_data = WIDTH'(lane[31:0]);
      default: ld_data = lane;
    endcase
  end

  always_comb begin
    accept      = in_valid && (state_q == StIdle) && !MAREGstall && !MAREGclear;
    go_bus      = accept && in_mem && !in_bad;
    timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 32'd1);
    state_d     = state_q;
    kill_d      = kill_q;
    to_fire     = 1'b0;
    case (state_q)
      StIdle: if (go_bus) state_d = StReq;
      StReq: begin
        if (MAREGclear) begin
          // A load granted in the flush cycle still owes an rvalid; absorb it silently
          if (dmem_gnt && !hold_we_q) begin
            state_d = StWait;
            kill_d  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (dmem_gnt) begin
          state_d = hold_we_q ? StDone : StWait;
        end else if (timeout_hit) begin
          state_d = StDone;
          to_fire = 1'b1;
        end
      end
      StWait: begin
        if (dmem_rvalid || timeout_hit) begin
          state_d = (kill_q || MAREGclear) ? StIdle : StDone;
          to_fire = !dmem_rvalid;
        end else if (MAREGclear) begin
          kill_d = 1'b1;
        end
      end
      default: if (MAREGclear || !MAREGstall) state_d = StIdle;
    endcase
    if (state_d == StIdle) kill_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      kill_q          <= 1'b0;
      cnt_q           <= '0;
      hold_rd_q       <= '0;
      hold_addr_q     <= '0;
      hold_wdata_q    <= '0;
      hold_be_q       <= '0;
      hold_pc_q       <= '0;
      hold_regwrite_q <= 1'b0;
      hold_mem2reg_q  <= '0;
      hold_we_q       <= 1'b0;
      hold_funct3_q   <= '0;
      hold_data_q     <= '0;
      hold_exc_q      <= '0;
      out_valid       <= 1'b0;
      out_rd          <= '0;
      out_result      <= '0;
      out_dmemdata    <= '0;
      out_pc          <= '0;
      out_regwrite    <= 1'b0;
      out_mem2reg     <= '0;
      out_exc         <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if ((state_q == StReq) || (state_q == StWait)) begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (go_bus) begin
        hold_rd_q       <= in_rd;
        hold_addr_q     <= in_aluresult;
        hold_wdata_q    <= in_wdata;
        hold_be_q       <= in_be;
        hold_pc_q       <= in_pc;
        hold_regwrite_q <= in_regwrite;
        hold_mem2reg_q  <= in_mem2reg;
        hold_we_q       <= in_memwrite;
        hold_funct3_q   <= in_funct3;
        hold_data_q     <= '0;
        hold_exc_q      <= 2'd0;
      end
      if ((state_q == StWait) && dmem_rvalid) hold_data_q <= ld_data;
      if (to_fire) hold_exc_q <= 2'd2;

      if (MAREGclear) begin
        out_valid    <= 1'b0;
        out_rd       <= '0;
        out_result   <= '0;
        out_dmemdata <= '0;
        out_pc       <= '0;
        out_regwrite <= 1'b0;
        out_mem2reg  <= '0;
        out_exc      <= '0;
      end else if (!MAREGstall) begin
        if (accept) begin
          out_rd       <= in_rd;
          out_result   <= in_aluresult;
          out_dmemdata <= '0;
          out_pc       <= in_pc;
          out_mem2reg  <= in_mem2reg;
          if (!in_mem) begin
            out_valid    <= 1'b1;
            out_regwrite <= in_regwrite;
            out_exc      <= 2'd0;
          end else if (in_bad) begin
            out_valid    <= 1'b1;
            out_regwrite <= 1'b0;
            out_exc      <= 2'd1;
          end else begin
            out_valid    <= 1'b0;
            out_regwrite <= 1'b0;
            out_exc      <= 2'd0;
          end
        end else if (state_q == StDone) begin
          out_valid    <= 1'b1;
          out_rd       <= hold_rd_q;
          out_result   <= hold_addr_q;
          out_dmemdata <= hold_data_q;
          out_pc       <= hold_pc_q;
          out_regwrite <= hold_regwrite_q && (hold_exc_q == 2'd0);
          out_mem2reg  <= hold_mem2reg_q;
          out_exc      <= hold_exc_q;
        end else begin
          out_valid    <= 1'b0;
          out_regwrite <= 1'b0;
        end
      end
    end
  end

  assign ma_busy    = (state_q != StIdle);
  assign dmem_req   = (state_q == StReq);
  assign dmem_we    = dmem_req && hold_we_q;
  assign dmem_addr  = {hold_addr_q[WIDTH-1:OFFW], {OFFW{1'b0}}};
  assign dmem_be    = hold_be_q;
  assign dmem_wdata = hold_wdata_q;

endmodule

// File: doc/memaccess_hs.md
Name: memaccess_hs

Overview:
- Parametrised successor to the existing single-cycle Memory Access stage of the in-order RV32I pipeline.
- Drives data memory through a req/gnt/rvalid handshake, so memories with variable latency work.
- Generates byte enables, lane-aligned write data and sign/zero-extended load data.
- Detects misaligned accesses and bus timeouts, stalls upstream while a transaction is open, and registers results into the MA->WB pipeline register.

Parameters:
- WIDTH, 32, datapath width; 32 or 64 (64 adds LD/SD/LWU).
- TIMEOUT, 0, cycles to wait in REQ or WAIT before a bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- MAREGclear  in  1  synchronous flush
- MAREGstall  in  1  WB not ready; freezes the output register and blocks accept
- in_valid  in  1  valid instruction from EX
- in_rd  in  5  destination register
- in_aluresult  in  WIDTH  address, or result for non-memory ops
- in_reg2data  in  WIDTH  store data
- in_pc  in  WIDTH  instruction PC
- in_regwrite  in  1  register write enable
- in_mem2reg  in  2  WB mux select
- in_memread  in  1  load
- in_memwrite  in  1  store
- in_funct3  in  3  access size and signedness
- ma_busy  out  1  stage cannot accept (equals state!=IDLE)
- dmem_req  out  1  bus request
- dmem_we  out  1  store
- dmem_addr  out  WIDTH  word/dword-aligned address
- dmem_be  out  WIDTH/8  byte enables
- dmem_wdata  out  WIDTH  lane-aligned store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  WIDTH  load data
- out_valid, out_rd, out_result, out_dmemdata, out_pc, out_regwrite, out_mem2reg  out  pipeline register to WB
- out_exc  out  2  exception code: 0 none, 1 misaligned, 2 bus timeout

Behaviour:
- Reset: every output and internal register is 0; state = IDLE.
- States: IDLE, REQ, WAIT, DONE.
- Accept: occurs when in_valid & state==IDLE & !MAREGstall & !MAREGclear.
  - Non-memory op: loads the output register at the edge, out_valid=1 next cycle. One-cycle latency.
  - Misaligned memory op: loads the output register with out_exc=1 and out_regwrite=0. No bus activity.
  - Misaligned means half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0.
  - Aligned memory op: captures op fields into the hold register and moves to REQ. Output register loads out_valid=0 (bubble) unless MAREGstall holds it.
- REQ:
  - dmem_req=1; addr/we/be/wdata come from the hold register and stay stable until gnt.
  - On gnt, a store completes: moves to DONE.
  - On gnt, a load moves to WAIT.
- WAIT:
  - rvalid is honoured no earlier than the cycle after gnt.
  - On rvalid, the extended load data is captured into the hold register and the state moves to DONE.
- DONE: when !MAREGstall, loads the output register from the hold register (out_valid=1) and returns to IDLE.
- Minimum load latency (accept to out_valid) is 4 cycles; minimum store latency is 3 cycles.
- Byte enables: byte=1<<addr[k:0], half=3<<addr, word=0xF<<addr, dword=0xFF, where k=1 for WIDTH 32 and k=2 for WIDTH 64. wdata replicates the low size-bytes of reg2data across all lanes.
- Load extension: the lane is selected by the low address bits.
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD passes through.
  - funct3 values not legal for WIDTH are treated as misaligned (exc=1).
- Timeout:
  - If TIMEOUT>0, a counter increments in REQ/WAIT and resets on each state change.
  - Reaching TIMEOUT drops req and moves to DONE with out_exc=2, out_regwrite=0.
  - A late rvalid after the timeout is ignored.
- MAREGclear:
  - Clears the output register (out_valid=0, out_regwrite=0) at the edge, and takes priority over MAREGstall.
  - In REQ before gnt: req is withdrawn and the state goes to IDLE.
  - In WAIT: a kill flag is set, the state stays in WAIT until rvalid (or timeout), the data is discarded, and the state returns to IDLE without a write.
  - In DONE: the state goes to IDLE with no output.
  - A store already granted is not undone.
- MAREGstall: the output register holds its value; bus transactions in REQ/WAIT continue. Stall has no effect on a DONE->IDLE transition until it is released.
- Reset mid-transaction: the state returns to IDLE immediately and req drops asynchronously.

Test Plan:
- LB from 0x1003 with rdata=0x80FF_FFFF, gnt cycle 1, rvalid cycle 2 -> be=0x8, out_dmemdata=0xFFFF_FF80, out_valid 4 cycles after accept.
- SH of 0x1234ABCD to 0x2002, gnt delayed 3 cycles -> dmem_req held 4 cycles, be=0xC, wdata=0xABCD_ABCD, ma_busy high throughout, out_regwrite=0.
- LW to 0x1001 -> no dmem_req, out_exc=1, out_regwrite=0 one cycle after accept.
- MAREGclear during WAIT, then rvalid -> no out_valid, state IDLE, next instruction accepted the following cycle.
- TIMEOUT=8, gnt never asserted -> req drops after 8 cycles, out_exc=2.
- WIDTH=64, LWU from 0x...04 with rdata=0xF000_0000_xxxx_xxxx -> out_dmemdata=0x0000_0000_F000_0000, be=0xF0.
